instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 112 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch FSM with bounded prefetch queue
module instruction_fetch #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  input  logic [INSTR_WIDTH-1:0] mem_instr,
  input  logic                   mem_instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_out_valid,
  input  logic                   instr_out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   inflight_q, inflight_d;
  logic [INSTR_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]          count_q;
  logic                   push, pop, issue, eop;

  // Queue control: a word arriving with valid=0 marks end of program; issue only
  // while queued plus outstanding words leave room, so a push never meets a full queue.
  always_comb begin
    eop   = (state_q == S_FETCH) && inflight_q && !mem_instr_valid;
    push  = (state_q == S_FETCH) && inflight_q && mem_instr_valid;
    issue = (state_q == S_FETCH) && !eop &&
            ((count_q + CW'(inflight_q)) < DEPTH_C);
    pop   = instr_out_valid && instr_out_ready;
  end

  // Next-state logic: program counter, in-flight flag and FSM transitions.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d       = start_addr;
          inflight_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        inflight_d = issue;
        if (issue) pc_d = pc_q + ADDR_WIDTH'(1);
        if (eop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Any response still returning after end detection is dropped here.
        inflight_d = 1'b0;
        if ((count_q == '0) && !inflight_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pc and queue pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage; contents are masked by the occupancy count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_instr;
  end

  // Outputs decoded from registers only.
  always_comb begin
    mem_address     = pc_q;
    instr_out_valid = (count_q != '0);
    instr_out       = instr_out_valid ? fifo_q[rd_ptr_q] : '0;
    busy            = (state_q == S_FETCH) || (state_q == S_DRAIN);
    done            = (state_q == S_DONE);
  end

endmodule
